// File: rtl/spi_slv.sv
// 16-bit SPI mode-0 slave: oversampled in the clk domain, MSB-first, full duplex.
// Optional SPI_SLV_MISO_TRISTATE_EN releases MISO to high-Z while SS_n is high.
`timescale 1ns/1ps
module spi_slv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] tx_data,
  input  logic        wrt,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic [15:0] cmd_rcvd,
  output logic        cmd_rdy,
  output logic        rsp_rdy
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 5;
  localparam logic [CNT_W-1:0] BITS_FULL = CNT_W'(WORD_W);

  logic              ss_ff1, ss_ff2, ss_ff3;
  logic              sclk_ff1, sclk_ff2, sclk_ff3;
  logic              mosi_ff1, mosi_ff2;
  logic              mosi_hold;
  logic [WORD_W-1:0] tx_buf;
  logic [WORD_W-1:0] shift;
  logic [CNT_W-1:0]  bit_cnt;

  logic ss_fall_c, ss_rise_c, ss_low_c, sclk_rise_c, sclk_fall_c, frame_full_c;

  // Two-flop synchronizers; a third stage on SS_n/SCLK for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ss_ff3, ss_ff2, ss_ff1}       <= 3'b111;
      {sclk_ff3, sclk_ff2, sclk_ff1} <= 3'b000;
      {mosi_ff2, mosi_ff1}           <= 2'b00;
    end else begin
      {ss_ff3, ss_ff2, ss_ff1}       <= {ss_ff2, ss_ff1, SS_n};
      {sclk_ff3, sclk_ff2, sclk_ff1} <= {sclk_ff2, sclk_ff1, SCLK};
      {mosi_ff2, mosi_ff1}           <= {mosi_ff1, MOSI};
    end
  end

  always_comb begin
    ss_fall_c    = ss_ff3 & ~ss_ff2;
    ss_rise_c    = ~ss_ff3 & ss_ff2;
    ss_low_c     = ~ss_ff2;
    sclk_rise_c  = ~sclk_ff3 & sclk_ff2;
    sclk_fall_c  = sclk_ff3 & ~sclk_ff2;
    frame_full_c = (bit_cnt == BITS_FULL);
  end

  // Transmit buffer and response-pending flag; wrt wins over a coincident frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf  <= '0;
      rsp_rdy <= 1'b0;
    end else begin
      if (wrt) tx_buf <= tx_data;
      if (wrt)            rsp_rdy <= 1'b1;
      else if (ss_fall_c) rsp_rdy <= 1'b0;
    end
  end

  // Shift register, MOSI holding flop and saturating bit counter.
  // The fall after the 16th rise (SCLK returning to idle) must not shift:
  // bit 16 is supplied from the holding flop at frame end instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift     <= '0;
      bit_cnt   <= '0;
      mosi_hold <= 1'b0;
    end else if (ss_fall_c) begin
      shift   <= tx_buf;
      bit_cnt <= '0;
    end else if (ss_low_c) begin
      if (sclk_rise_c) begin
        mosi_hold <= mosi_ff2;
        if (!frame_full_c) bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (sclk_fall_c && !frame_full_c)
        shift <= {shift[WORD_W-2:0], mosi_hold};
    end
  end

  // Command capture on frame end; short frames are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_rcvd <= '0;
      cmd_rdy  <= 1'b0;
    end else if (ss_fall_c) begin
      cmd_rdy <= 1'b0;
    end else if (ss_rise_c && frame_full_c) begin
      cmd_rcvd <= {shift[WORD_W-2:0], mosi_hold};
      cmd_rdy  <= 1'b1;
    end
  end

`ifdef SPI_SLV_MISO_TRISTATE_EN
  assign MISO = SS_n ? 1'bz : shift[WORD_W-1];
`else
  assign MISO = SS_n ? 1'b0 : shift[WORD_W-1];
`endif

endmodule

// File: tb/tb_spi_slv.sv
// Self-checking bench for spi_slv: a bit-banged SPI master plus a word-level
// model of what the slave should report and transmit.
`timescale 1ns/1ps
module tb_spi_slv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] tx_data = '0;
  logic        wrt = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [15:0] cmd_rcvd;
  logic        cmd_rdy;
  logic        rsp_rdy;

  always #5 clk = ~clk;

  spi_slv dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .wrt(wrt),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .cmd_rcvd(cmd_rcvd), .cmd_rdy(cmd_rdy), .rsp_rdy(rsp_rdy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Word-level model
  logic [15:0] m_buf = '0;
  logic [15:0] m_cmd = '0;
  logic        m_cmd_rdy = 1'b0;
  logic        m_rsp_rdy = 1'b0;
  logic        idle_miso;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_wrt(input logic [15:0] d);
    tx_data = d;
    wrt = 1'b1;
    wait_clk(1);
    wrt = 1'b0;
    m_buf = d;
    m_rsp_rdy = 1'b1;
  endtask

  // One SCLK period (clk/16): set MOSI, rise (master samples MISO), fall
  task automatic spi_bit(input logic mo, output logic mi);
    MOSI = mo;
    wait_clk(8);
    SCLK = 1'b1;
    mi = MISO;
    wait_clk(8);
    SCLK = 1'b0;
  endtask

  // wrt_at: -1 none, -2 in the cycle the slave sees SS_n fall, k>=0 before bit k
  task automatic spi_frame(input logic [15:0] mo, input int nbits,
                           input int wrt_at, input logic [15:0] wdata);
    logic [15:0] exp_tx, got;
    logic        mi, prev_rdy;
    exp_tx = m_buf;
    m_cmd_rdy = 1'b0;
    m_rsp_rdy = 1'b0;
    SS_n = 1'b0;
    if (wrt_at == -2) begin
      wait_clk(2);
      pulse_wrt(wdata);
    end
    wait_clk(8);
    check("start_cmd_rdy", 16'(cmd_rdy), 16'(m_cmd_rdy));
    check("start_rsp_rdy", 16'(rsp_rdy), 16'(m_rsp_rdy));
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      if (i == wrt_at) pulse_wrt(wdata);
      spi_bit(mo[15-i], mi);
      got = {got[14:0], mi};
    end
    check("miso_word", got, exp_tx >> (16 - nbits));
    wait_clk(8);
    prev_rdy = m_cmd_rdy;
    SS_n = 1'b1;
    #1;
    check("miso_idle", 16'(MISO), 16'(idle_miso));
    if (nbits == 16) begin
      m_cmd = mo;
      m_cmd_rdy = 1'b1;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    check("cmd_rdy_lat2", 16'(cmd_rdy), 16'(prev_rdy));
    @(posedge clk);
    #1;
    check("cmd_rdy_lat3", 16'(cmd_rdy), 16'(m_cmd_rdy));
    check("cmd_rcvd", cmd_rcvd, m_cmd);
    check("end_rsp_rdy", 16'(rsp_rdy), 16'(m_rsp_rdy));
    wait_clk(1);
  endtask

  initial begin
    logic mi;
    int   nb;
`ifdef SPI_SLV_MISO_TRISTATE_EN
    idle_miso = 1'bz;
`else
    idle_miso = 1'b0;
`endif
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    check("rst_cmd_rdy", 16'(cmd_rdy), 16'h0);
    check("rst_rsp_rdy", 16'(rsp_rdy), 16'h0);
    check("rst_cmd_rcvd", cmd_rcvd, 16'h0000);
    check("rst_miso", 16'(MISO), 16'(idle_miso));

    spi_frame(16'h4A5C, 16, -1, 16'h0);
    wait_clk(20);
    check("cmd_rdy_hold", 16'(cmd_rdy), 16'(m_cmd_rdy));

    pulse_wrt(16'hA5A5);
    check("wrt_rsp_rdy", 16'(rsp_rdy), 16'(m_rsp_rdy));
    spi_frame(16'h0000, 16, -1, 16'h0);

    // Aborted frame, then a full one
    spi_frame(16'h1234, 9, -1, 16'h0);
    spi_frame(16'h0123, 16, -1, 16'h0);

    // Back-to-back frames retransmit the same buffer
    spi_frame(16'h0100, 16, -1, 16'h0);
    spi_frame(16'h4155, 16, -1, 16'h0);

    // wrt mid-frame, then wrt coincident with the frame start
    spi_frame(16'h5A3C, 16, 5, 16'h1357);
    spi_frame(16'hBEEF, 16, -2, 16'h2468);
    spi_frame(16'hC001, 16, -1, 16'h0);

    for (int k = 0; k < 8; k++) begin
      if (($urandom % 2) == 0) pulse_wrt(16'($urandom));
      nb = (($urandom % 4) == 0) ? int'($urandom_range(15, 1)) : 16;
      spi_frame(16'($urandom), nb, -1, 16'h0);
    end

    // Reset in the middle of a frame
    SS_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) pulse_wrt(16'h9ABC);
      spi_bit(1'($urandom), mi);
    end
    rst_n = 1'b0;
    m_buf = '0;
    m_cmd = '0;
    m_cmd_rdy = 1'b0;
    m_rsp_rdy = 1'b0;
    #1;
    check("midrst_cmd_rdy", 16'(cmd_rdy), 16'(m_cmd_rdy));
    check("midrst_rsp_rdy", 16'(rsp_rdy), 16'(m_rsp_rdy));
    check("midrst_cmd_rcvd", cmd_rcvd, m_cmd);
    wait_clk(2);
    SS_n = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(10);
    check("postrst_cmd_rdy", 16'(cmd_rdy), 16'(m_cmd_rdy));
    check("postrst_cmd_rcvd", cmd_rcvd, m_cmd);
    spi_frame(16'h0F0F, 16, -1, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
